grid_slide_merge: RTL and testbench

Parametrised successor to the 2048 movement FSM. It slides and merges an N x N board of W-bit tile values in one of four directions, one row or column per clock. It also reports score gained, whether the board changed, and (optionally) a win. It sits between the direction decoder and the random-tile spawner in game_logic.

---
 rtl/grid_slide_merge.sv | 223 ++++++++++++++++++++++
 tb/tb_grid_slide_merge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/grid_slide_merge.sv
// grid_slide_merge
//   Slides and merges an N x N board of W-bit tile values in one of four
//   directions, one row/column per clock, then publishes the result with a
//   one-cycle ready pulse together with score gained, a changed flag and an
//   optional win flag.
//
// Optional feature macro: GRID_WIN_DETECT_EN
//   defined   : win is set when a merge produces WIN_VALUE
//   undefined : win is tied to 0 and no win comparators exist
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   enable       in   block enable; low aborts a move in progress
//   direction    in   one-hot request: 0001 up, 0010 down, 0100 left, 1000 right
//   matrix       in   current board [row][col], row 0 top, col 0 left
//   moved_matrix out  board result of the last completed move
//   ready        out  one-cycle pulse, results valid
//   busy         out  high while lines are being processed
//   changed      out  result differs from the captured board
//   score_delta  out  saturating sum of all tiles created by merges
//   win          out  a merge produced WIN_VALUE
module grid_slide_merge #(
  parameter int N         = 4,
  parameter int W         = 12,
  parameter int SCORE_W   = 16,
  parameter int WIN_VALUE = 2048
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [3:0]                    direction,
  input  logic [N-1:0][N-1:0][W-1:0]    matrix,
  output logic [N-1:0][N-1:0][W-1:0]    moved_matrix,
  output logic                          ready,
  output logic                          busy,
  output logic                          changed,
  output logic [SCORE_W-1:0]            score_delta,
  output logic                          win
);

  localparam int IDX_W = $clog2(N);
  localparam int SUM_W = W + 3;
  localparam int ACC_W = ((SCORE_W > SUM_W) ? SCORE_W : SUM_W) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_DONE
  } state_t;

  state_t                        state;
  logic [3:0]                    last_dir;
  logic [3:0]                    dir_q;
  logic [IDX_W-1:0]              idx;
  logic [N-1:0][N-1:0][W-1:0]    board_q;
  logic [N-1:0][N-1:0][W-1:0]    work;
  logic [SCORE_W-1:0]            score_acc;

  logic                          one_hot;
  logic                          trigger;
  logic [W-1:0]                  line_in  [N];
  logic [W-1:0]                  line_out [N];
  logic [SUM_W-1:0]              line_sum;
  logic [ACC_W-1:0]              acc_sum;
  logic [SCORE_W-1:0]            score_next;

  assign one_hot = (direction != '0) && ((direction & (direction - 4'd1)) == '0);
  assign trigger = enable && one_hot && (direction != last_dir);

  // Gather the current line ordered from the destination end (element 0
  // is the tile nearest the wall the move pushes toward).
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      line_in[k] = '0;
      case (dir_q)
        DIR_UP:    line_in[k] = board_q[k][idx];
        DIR_DOWN:  line_in[k] = board_q[N-1-k][idx];
        DIR_RIGHT: line_in[k] = board_q[idx][N-1-k];
        default:   line_in[k] = board_q[idx][k];
      endcase
    end
  end

`ifdef GRID_WIN_DETECT_EN
  logic line_win;
  logic win_acc;
`endif

  // Compact, merge in place, compact again. Each compaction pass pushes one
  // gap to the far end, so N-1 passes always suffice. After a merge the
  // partner slot becomes zero, which keeps the new tile from merging twice.
  always_comb begin
    logic [W-1:0] t [N];
    for (int unsigned k = 0; k < N; k++) t[k] = line_in[k];
    line_sum = '0;
`ifdef GRID_WIN_DETECT_EN
    line_win = 1'b0;
`endif
    for (int unsigned p = 0; p < N - 1; p++) begin
      for (int unsigned k = 0; k < N - 1; k++) begin
        if (t[k] == '0) begin
          t[k]   = t[k+1];
          t[k+1] = '0;
        end
      end
    end
    for (int unsigned k = 0; k < N - 1; k++) begin
      // top bit set means 2v would not fit in W bits: leave the pair alone
      if ((t[k] != '0) && (t[k] == t[k+1]) && !t[k][W-1]) begin
`ifdef GRID_WIN_DETECT_EN
        if ({t[k][W-2:0], 1'b0} == W'(WIN_VALUE)) line_win = 1'b1;
`endif
        line_sum = line_sum + SUM_W'({t[k], 1'b0});
        t[k]     = {t[k][W-2:0], 1'b0};
        t[k+1]   = '0;
      end
    end
    for (int unsigned p = 0; p < N - 1; p++) begin
      for (int unsigned k = 0; k < N - 1; k++) begin
        if (t[k] == '0) begin
          t[k]   = t[k+1];
          t[k+1] = '0;
        end
      end
    end
    for (int unsigned k = 0; k < N; k++) line_out[k] = t[k];
  end

  always_comb begin
    acc_sum    = ACC_W'(score_acc) + ACC_W'(line_sum);
    score_next = (acc_sum > ACC_W'(SCORE_MAX)) ? SCORE_MAX : acc_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      last_dir     <= '0;
      dir_q        <= '0;
      idx          <= '0;
      board_q      <= '0;
      work         <= '0;
      score_acc    <= '0;
      moved_matrix <= '0;
      ready        <= 1'b0;
      busy         <= 1'b0;
      changed      <= 1'b0;
      score_delta  <= '0;
`ifdef GRID_WIN_DETECT_EN
      win_acc      <= 1'b0;
      win          <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          ready <= 1'b0;
          // While disabled the remembered direction stays cleared, so a
          // direction held across an abort fires once enable returns.
          last_dir <= enable ? direction : 4'b0000;
          if (trigger) begin
            board_q   <= matrix;
            dir_q     <= direction;
            idx       <= '0;
            score_acc <= '0;
`ifdef GRID_WIN_DETECT_EN
            win_acc   <= 1'b0;
`endif
            busy      <= 1'b1;
            state     <= S_PROC;
          end
        end
        S_PROC: begin
          if (!enable) begin
            busy     <= 1'b0;
            last_dir <= '0;
            state    <= S_IDLE;
          end else begin
            for (int unsigned k = 0; k < N; k++) begin
              case (dir_q)
                DIR_UP:    work[k][idx]     <= line_out[k];
                DIR_DOWN:  work[N-1-k][idx] <= line_out[k];
                DIR_RIGHT: work[idx][N-1-k] <= line_out[k];
                default:   work[idx][k]     <= line_out[k];
              endcase
            end
            score_acc <= score_next;
`ifdef GRID_WIN_DETECT_EN
            win_acc   <= win_acc | line_win;
`endif
            if (idx == IDX_W'(N - 1)) begin
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          moved_matrix <= work;
          changed      <= (work != board_q);
          score_delta  <= score_acc;
`ifdef GRID_WIN_DETECT_EN
          win          <= win_acc;
`endif
          ready        <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef GRID_WIN_DETECT_EN
  assign win = 1'b0;
`endif

endmodule

// File: tb/tb_grid_slide_merge.sv
module tb_grid_slide_merge;

  typedef logic [3:0][3:0][11:0] board_t;

  typedef struct {
    string       name;
    board_t      brd;
    logic [3:0]  dir;
    board_t      exp_brd;
    logic        exp_chg;
    int unsigned exp_score;
    logic        exp_win;
  } vec_t;

`ifdef GRID_WIN_DETECT_EN
  localparam logic WIN_ON = 1'b1;
`else
  localparam logic WIN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  direction;
  board_t      matrix;
  board_t      moved_matrix;
  logic        ready;
  logic        busy;
  logic        changed;
  logic [15:0] score_delta;
  logic        win;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  vec_t        vecs [10];

  grid_slide_merge #(.N(4), .W(12), .SCORE_W(16), .WIN_VALUE(2048)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .direction    (direction),
    .matrix       (matrix),
    .moved_matrix (moved_matrix),
    .ready        (ready),
    .busy         (busy),
    .changed      (changed),
    .score_delta  (score_delta),
    .win          (win)
  );

  always #5 clk = ~clk;

  function automatic board_t bd(input int unsigned v [16]);
    board_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = 12'(v[r*4+c]);
    return b;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    direction = 4'b0000;
    repeat (2) @(posedge clk);
  endtask

  // Trigger edge is the first posedge after inputs settle; returns the
  // number of edges after it at which ready was seen (-1 if never).
  task automatic apply(input string nm, input board_t b, input logic [3:0] d, output int lat);
    @(negedge clk);
    matrix    = b;
    direction = d;
    @(posedge clk); #1;
    chk({nm, "_busy"}, 192'(busy), 192'(1'b1));
    matrix = ~b;  // board must have been captured at trigger
    lat = -1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic add(input int i, input string nm, input board_t b, input logic [3:0] d,
                     input board_t eb, input logic ec, input int unsigned es, input logic ew);
    vecs[i].name      = nm;
    vecs[i].brd       = b;
    vecs[i].dir       = d;
    vecs[i].exp_brd   = eb;
    vecs[i].exp_chg   = ec;
    vecs[i].exp_score = es;
    vecs[i].exp_win   = ew;
  endtask

  initial begin
    int     lat;
    int     cnt;
    board_t b1, b1_left;

    b1      = bd('{0,0,0,0,  0,4,2,0,  0,8,8,0,  0,0,0,0});
    b1_left = bd('{0,0,0,0,  4,2,0,0,  16,0,0,0, 0,0,0,0});

    add(0, "left_b1", b1, 4'b0100, b1_left, 1'b1, 16, 1'b0);
    add(1, "up_b1", b1, 4'b0001,
        bd('{0,4,2,0,  0,8,8,0,  0,0,0,0,  0,0,0,0}), 1'b1, 0, 1'b0);
    add(2, "right_2222", bd('{2,2,2,2, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 4'b1000,
        bd('{0,0,4,4, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 1'b1, 8, 1'b0);
    add(3, "ovf_left", bd('{2048,2048,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 4'b0100,
        bd('{2048,2048,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 1'b0, 0, 1'b0);
    add(4, "ovf_again", bd('{2048,2048,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 4'b0100,
        bd('{2048,2048,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 1'b0, 0, 1'b0);
    add(5, "ovf_compact", bd('{0,2048,0,2048, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 4'b0100,
        bd('{2048,2048,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 1'b1, 0, 1'b0);
    add(6, "win_1024", bd('{1024,1024,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 4'b0100,
        bd('{2048,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0}), 1'b1, 2048, WIN_ON);
    add(7, "left_mixed", bd('{4,0,4,8, 2,2,4,0, 0,0,0,0, 8,0,0,8}), 4'b0100,
        bd('{8,8,0,0, 4,4,0,0, 0,0,0,0, 16,0,0,0}), 1'b1, 28, 1'b0);
    add(8, "down_mixed", bd('{2,0,0,8, 2,0,0,0, 4,0,0,0, 4,0,0,8}), 4'b0010,
        bd('{0,0,0,0, 0,0,0,0, 4,0,0,0, 8,0,0,16}), 1'b1, 28, 1'b0);
    add(9, "right_444", bd('{0,4,4,4, 2,0,0,2, 0,0,0,0, 0,0,0,0}), 4'b1000,
        bd('{0,0,4,8, 0,0,0,4, 0,0,0,0, 0,0,0,0}), 1'b1, 12, 1'b0);

    // reset then idle
    rst = 1'b0; enable = 1'b1; direction = 4'b0000; matrix = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_matrix", 192'(moved_matrix), 192'(0));
    chk("rst_flags", 192'({ready, busy, changed, win}), 192'(0));
    chk("rst_score", 192'(score_delta), 192'(0));
    @(negedge clk); rst = 1'b1;
    cnt = 0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      if (ready || busy) cnt++;
    end
    chk("idle_quiet", 192'(cnt), 192'(0));

    // vector table
    for (int i = 0; i < 10; i++) begin
      go_idle();
      apply(vecs[i].name, vecs[i].brd, vecs[i].dir, lat);
      chk({vecs[i].name, "_lat"}, 192'(lat), 192'(5));
      chk({vecs[i].name, "_board"}, 192'(moved_matrix), 192'(vecs[i].exp_brd));
      chk({vecs[i].name, "_chg"}, 192'(changed), 192'(vecs[i].exp_chg));
      chk({vecs[i].name, "_score"}, 192'(score_delta), 192'(vecs[i].exp_score));
      chk({vecs[i].name, "_win"}, 192'(win), 192'(vecs[i].exp_win));
    end

    // holding the same direction must not retrigger
    go_idle();
    apply("hold", vecs[2].brd, 4'b1000, lat);
    chk("hold_lat", 192'(lat), 192'(5));
    cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (ready || busy) cnt++;
    end
    chk("hold_no_retrigger", 192'(cnt), 192'(0));

    // multi-hot never triggers
    go_idle();
    @(negedge clk); matrix = b1; direction = 4'b0101;
    cnt = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (ready || busy) cnt++;
    end
    chk("multihot_ignored", 192'(cnt), 192'(0));

    // abort on the 2nd PROC cycle; prior result is right_2222
    go_idle();
    @(negedge clk); matrix = b1; direction = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 192'(busy), 192'(0));
    cnt = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (ready) cnt++;
    end
    chk("abort_no_ready", 192'(cnt), 192'(0));
    chk("abort_keep_board", 192'(moved_matrix), 192'(vecs[2].exp_brd));
    chk("abort_keep_score", 192'(score_delta), 192'(8));
    // direction still held: must fire once enable returns
    enable = 1'b1;
    lat = -1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = e;
        break;
      end
    end
    chk("reenable_lat", 192'(lat), 192'(6));
    chk("reenable_board", 192'(moved_matrix), 192'(b1_left));

    // async reset mid-PROC
    go_idle();
    @(negedge clk); matrix = b1; direction = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 192'(busy), 192'(0));
    chk("arst_board", 192'(moved_matrix), 192'(0));
    chk("arst_score", 192'(score_delta), 192'(0));
    @(negedge clk); rst = 1'b1; direction = 4'b0000;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
